idpair_packer: RTL and testbench
================================

Name: idpair_packer

Overview:
Consumer end of the tanimoto_top ID-pair output interface. It drains matched (ID_A, ID_B) pairs through the o_IDPair_Ready / i_IDPair_Read handshake and packs them into BUS_WIDTH-wide words. It then pushes those words into a downstream write FIFO or DMA buffer using a write/full handshake. On request it flushes a final partial word so the host receives every pair.

Parameters:
BUS_WIDTH, 512, width of packed output word
VECTOR_WIDTH, 920, fingerprint width; sets default ID width
VEC_ID_WIDTH, $clog2(VECTOR_WIDTH) = 10, width of one vector ID
PAIR_WIDTH, 2*VEC_ID_WIDTH = 20, derived, width of one ID pair
PAIRS_PER_WORD, BUS_WIDTH/PAIR_WIDTH = 25, derived, number of pair slots per word
COUNT_W, $clog2(PAIRS_PER_WORD+1) = 5, derived, width of the valid-pair count field

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
i_IDPair_Ready  in  1  upstream has a pair at i_IDPair_Out (first-word fall-through)
i_IDPair_Out  in  PAIR_WIDTH  current upstream pair
o_IDPair_Read  out  1  pop strobe to upstream; a pair is consumed when Ready && Read
o_Word  out  BUS_WIDTH  packed output word
o_Write  out  1  write strobe to downstream; word transferred when asserted
i_Full  in  1  downstream cannot accept a word
i_Flush  in  1  single-cycle request to emit the partial word
o_FlushDone  out  1  single-cycle pulse when the flush has completed
o_PairCount  out  32  total pairs consumed since reset, wrapping
o_Busy  out  1  accumulator or output register holds data

Behaviour:
- Reset (rstn=0, async): slot counter=0, accumulator=0, output register empty, FSM=S_RUN, o_PairCount=0. All outputs are 0. Reset mid-word discards the partial data.
- Word format:
  - Pair in slot k occupies bits [k*PAIR_WIDTH +: PAIR_WIDTH]; slot 0 is the first pair received.
  - Unused slots are 0.
  - Bits [BUS_WIDTH-1 -: COUNT_W] hold the number of valid pairs (1..PAIRS_PER_WORD).
  - Elaboration check: BUS_WIDTH - PAIRS_PER_WORD*PAIR_WIDTH >= COUNT_W, otherwise $error.
- Slot counter cnt ranges 0..PAIRS_PER_WORD.
- o_IDPair_Read = i_IDPair_Ready && cnt < PAIRS_PER_WORD && FSM==S_RUN && !i_Flush. It is combinational.
- On a pop, i_IDPair_Out is latched into slot cnt, cnt increments, and o_PairCount increments.
- Transfer from accumulator to output register:
  - Occurs when (cnt==PAIRS_PER_WORD, or FSM==S_FLUSH_MOVE with cnt>0) and the output register is empty or written this cycle.
  - On transfer, cnt returns to 0 and the accumulator is cleared.
  - No pop is allowed in a cycle with cnt==PAIRS_PER_WORD, so sustained throughput is 25 pairs per 26 cycles.
- Output register:
  - o_Write = out_valid && !i_Full, combinational.
  - o_Word is driven from the register and held stable while i_Full is asserted.
  - After the last pop of a word at edge N, the first o_Write cycle is N+1, provided i_Full=0.
- FSM:
  - S_RUN: i_Flush moves to S_FLUSH_MOVE.
  - S_FLUSH_MOVE:
    - If cnt>0: wait for the transfer, then go to S_FLUSH_DRAIN.
    - If cnt==0: go directly to S_FLUSH_DRAIN.
  - S_FLUSH_DRAIN: once out_valid==0, pulse o_FlushDone for one cycle and return to S_RUN.
  - An i_Flush outside S_RUN is ignored.
  - A flush with nothing buffered produces no write; o_FlushDone pulses 2 cycles after i_Flush.
- Simultaneous events:
  - i_Flush in the same cycle as i_IDPair_Ready: the pop is suppressed; the pair stays upstream.
  - A transfer and an o_Write in the same cycle: the register reloads with no bubble.
- o_Busy = (cnt != 0) || out_valid.

Decomposition:
- Shared header (included like the other tanimoto sources) defines the derived constants PAIR_WIDTH, PAIRS_PER_WORD, COUNT_W and the FSM state encodings S_RUN=2'd0, S_FLUSH_MOVE=2'd1, S_FLUSH_DRAIN=2'd2.
- One natural sub-module, idpair_out_reg: a single-entry word holding register with load/valid/full handshake, reusable for other result streams.

Test Plan:
1. Reset, then 25 pairs with ID_A=i, ID_B=i+100 (i=0..24) and i_Full=0 -> exactly one o_Write. Slot k = {k+100, k}, bits[511:507]=25. o_PairCount=25.
2. 60 back-to-back pairs with i_Ready held high -> o_IDPair_Read drops for 1 cycle after each 25th pop. Two full words are written; o_Busy=1 with 10 pairs pending.
3. 7 pairs, then i_Flush -> one word with count field 7, slots 7..24 zero. o_FlushDone pulses once after the write.
4. Full word ready while i_Full=1 for 20 cycles; 30 more pairs offered -> o_Word stable and o_Write=0 throughout. 25 pops accepted, then read stalls; on release, two words are written in order.
5. i_Flush with empty packer -> no o_Write; o_FlushDone 2 cycles later. i_Flush coincident with i_Ready -> that pair is not popped.
6. rstn low after 12 pops -> all outputs 0 immediately. After release, next 25 pairs form a clean word with count 25.

Source files
------------

// File: rtl/idpair_packer_pkg.sv
// Shared constants and FSM encoding for the ID-pair packer and its bench.
// Derived widths follow the tanimoto defaults: 10-bit IDs, 20-bit pairs, 25 slots.
package idpair_packer_pkg;

    localparam int BUS_WIDTH_DEF    = 512;
    localparam int VECTOR_WIDTH_DEF = 920;
    localparam int VEC_ID_WIDTH_DEF = $clog2(VECTOR_WIDTH_DEF);
    localparam int PAIR_WIDTH_DEF   = 2 * VEC_ID_WIDTH_DEF;

    typedef enum logic [1:0] {
        S_RUN         = 2'd0,
        S_FLUSH_MOVE  = 2'd1,
        S_FLUSH_DRAIN = 2'd2
    } state_t;

    function automatic int pairs_per_word(input int bus_w, input int pair_w);
        return bus_w / pair_w;
    endfunction

    function automatic int count_width(input int bus_w, input int pair_w);
        return $clog2(pairs_per_word(bus_w, pair_w) + 1);
    endfunction

endpackage

// File: rtl/idpair_packer_if.sv
// Pair-in / word-out bundle between the tanimoto pair stream, the packer and the write FIFO.
// The master side drives the upstream pair and downstream back-pressure.
interface idpair_packer_if
    import idpair_packer_pkg::*;
#(
    parameter int PAIR_WIDTH = PAIR_WIDTH_DEF,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF
);
    logic                  i_IDPair_Ready;
    logic [PAIR_WIDTH-1:0] i_IDPair_Out;
    logic                  o_IDPair_Read;
    logic [BUS_WIDTH-1:0]  o_Word;
    logic                  o_Write;
    logic                  i_Full;
    logic                  i_Flush;
    logic                  o_FlushDone;
    logic [31:0]           o_PairCount;
    logic                  o_Busy;

    modport master (
        output i_IDPair_Ready, i_IDPair_Out, i_Full, i_Flush,
        input  o_IDPair_Read, o_Word, o_Write, o_FlushDone, o_PairCount, o_Busy
    );

    modport slave (
        input  i_IDPair_Ready, i_IDPair_Out, i_Full, i_Flush,
        output o_IDPair_Read, o_Word, o_Write, o_FlushDone, o_PairCount, o_Busy
    );
endinterface

// File: rtl/idpair_out_reg.sv
// Single-entry holding register for a result word with load / valid / full handshake.
// ready_o is high when empty or when the held word leaves this cycle, allowing bubble-free reload.
module idpair_out_reg #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             full_i,
    output logic             valid_o,
    output logic             ready_o,
    output logic             write_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign write_o = valid_q && !full_i;
    assign ready_o = !valid_q || write_o;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (write_o) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/idpair_packer.sv
// Drains (ID_A, ID_B) pairs into 25-slot words with a pair count in the top bits,
// and emits a trailing partial word on flush.
module idpair_packer
    import idpair_packer_pkg::*;
#(
    parameter int BUS_WIDTH    = BUS_WIDTH_DEF,
    parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rstn,
    idpair_packer_if.slave bus
);
    localparam int VEC_ID_WIDTH   = $clog2(VECTOR_WIDTH);
    localparam int PAIR_WIDTH     = 2 * VEC_ID_WIDTH;
    localparam int PAIRS_PER_WORD = pairs_per_word(BUS_WIDTH, PAIR_WIDTH);
    localparam int COUNT_W        = count_width(BUS_WIDTH, PAIR_WIDTH);
    localparam int PAYLOAD_W      = PAIRS_PER_WORD * PAIR_WIDTH;
    localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(PAIRS_PER_WORD);

    if (BUS_WIDTH - PAYLOAD_W < COUNT_W) begin : g_width_check
        $error("idpair_packer: no room for the count field above the pair slots");
    end

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]          pair_count_q;
    logic [PAYLOAD_W-1:0] payload;
    logic [BUS_WIDTH-1:0] word;
    logic                 pop, xfer, flush_done;
    logic                 out_valid, out_ready, out_write;

    // A full accumulator blocks popping until it has moved to the output register.
    assign pop  = bus.i_IDPair_Ready && (cnt_q < CNT_FULL) && (state_q == S_RUN) && !bus.i_Flush;
    assign xfer = ((cnt_q == CNT_FULL) || ((state_q == S_FLUSH_MOVE) && (cnt_q != '0))) && out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (xfer) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q        <= '0;
            pair_count_q <= '0;
            state_q      <= S_RUN;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            if (pop) begin
                pair_count_q <= pair_count_q + 32'd1;
            end
        end
    end

    for (genvar gi = 0; gi < PAIRS_PER_WORD; gi++) begin : g_slot
        logic [PAIR_WIDTH-1:0] slot_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                slot_q <= '0;
            end else if (xfer) begin
                slot_q <= '0;
            end else if (pop && (cnt_q == COUNT_W'(gi))) begin
                slot_q <= bus.i_IDPair_Out;
            end
        end

        assign payload[gi*PAIR_WIDTH +: PAIR_WIDTH] = slot_q;
    end

    always_comb begin
        word                        = '0;
        word[PAYLOAD_W-1:0]         = payload;
        word[BUS_WIDTH-1 -: COUNT_W] = cnt_q;
    end

    idpair_out_reg #(
        .WIDTH(BUS_WIDTH)
    ) u_out_reg (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (xfer),
        .data_i (word),
        .full_i (bus.i_Full),
        .valid_o(out_valid),
        .ready_o(out_ready),
        .write_o(out_write),
        .data_o (bus.o_Word)
    );

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            S_RUN: begin
                if (bus.i_Flush) begin
                    state_d = S_FLUSH_MOVE;
                end
            end
            S_FLUSH_MOVE: begin
                if ((cnt_q == '0) || xfer) begin
                    state_d = S_FLUSH_DRAIN;
                end
            end
            S_FLUSH_DRAIN: begin
                if (!out_valid) begin
                    flush_done = 1'b1;
                    state_d    = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign bus.o_IDPair_Read = pop;
    assign bus.o_Write       = out_write;
    assign bus.o_FlushDone   = flush_done;
    assign bus.o_PairCount   = pair_count_q;
    assign bus.o_Busy        = (cnt_q != '0) || out_valid;
endmodule

// File: tb/tb_idpair_packer.sv
// Directed bench for idpair_packer: a table of burst/flush scenarios plus hand-written
// sequences for flush timing, back-pressure and mid-word reset.
module tb_idpair_packer;
    import idpair_packer_pkg::*;

    localparam int BW  = 512;
    localparam int PW  = 20;
    localparam int PPW = 25;
    localparam int CW  = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    idpair_packer_if #(.PAIR_WIDTH(PW), .BUS_WIDTH(BW)) bus();

    idpair_packer #(
        .BUS_WIDTH   (BW),
        .VECTOR_WIDTH(920)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct {
        int npairs;
        bit flush;
        int exp_cycles;
        int exp_words;
        int exp_last;
        int exp_busy;
        int exp_pc;
    } vec_t;

    vec_t            tbl [6];
    int              n_cmp    = 0;
    int              n_bad    = 0;
    int              seq      = 0;
    int              done_cnt = 0;
    logic [PW-1:0]   pend [$];
    logic [BW-1:0]   exp_q [$];
    logic [BW-1:0]   got_q [$];

    always @(negedge clk) begin
        if (bus.o_Write) got_q.push_back(bus.o_Word);
        if (bus.o_FlushDone) done_cnt++;
    end

    function automatic logic [PW-1:0] mk(input int s);
        int t;
        logic [9:0] a, b;
        t = s + 100;
        a = s[9:0];
        b = t[9:0];
        return {b, a};
    endfunction

    function automatic logic [BW-1:0] build_word();
        logic [BW-1:0] w;
        w = '0;
        for (int k = 0; k < pend.size(); k++) w[k*PW +: PW] = pend[k];
        w[BW-1 -: CW] = CW'(pend.size());
        pend.delete();
        return w;
    endfunction

    task automatic model_pop();
        pend.push_back(mk(seq));
        seq++;
        if (pend.size() == PPW) exp_q.push_back(build_word());
    endtask

    task automatic model_flush();
        if (pend.size() > 0) exp_q.push_back(build_word());
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic check_word(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: count %0d", name, act[BW-1 -: CW]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers consecutive pairs; entered and left just after a rising edge.
    task automatic send_pairs(input string tag, input int n, output int cycles);
        int got;
        got    = 0;
        cycles = 0;
        while (got < n && cycles < 500) begin
            bus.i_IDPair_Ready = 1'b1;
            bus.i_IDPair_Out   = mk(seq);
            @(negedge clk);
            if (bus.o_IDPair_Read) begin
                model_pop();
                got++;
            end
            cycles++;
            @(posedge clk);
            #1;
        end
        bus.i_IDPair_Ready = 1'b0;
        if (got < n) check({tag, "_timeout"}, got, n);
    endtask

    task automatic do_flush();
        bus.i_Flush = 1'b1;
        model_flush();
        @(posedge clk);
        #1;
        bus.i_Flush = 1'b0;
    endtask

    task automatic check_words(input string tag, input int exp_n, input int exp_last);
        check({tag, "_nwords"}, got_q.size(), exp_n);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_word($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        if (got_q.size() > 0)
            check({tag, "_countfield"}, int'(got_q[got_q.size()-1][BW-1 -: CW]), exp_last);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"},  int'(bus.o_IDPair_Read), 0);
        check({tag, "_write"}, int'(bus.o_Write), 0);
        check({tag, "_word_zero"}, int'(bus.o_Word == '0), 1);
        check({tag, "_done"},  int'(bus.o_FlushDone), 0);
        check({tag, "_pc"},    int'(bus.o_PairCount), 0);
        check({tag, "_busy"},  int'(bus.o_Busy), 0);
    endtask

    initial begin
        int cyc, d0, pops, writes, stable_bad;
        logic [BW-1:0] ref_word;

        tbl[0] = '{npairs: 25, flush: 1'b0, exp_cycles: 25, exp_words: 1, exp_last: 25, exp_busy: 0, exp_pc: 25};
        tbl[1] = '{npairs: 60, flush: 1'b0, exp_cycles: 62, exp_words: 2, exp_last: 25, exp_busy: 1, exp_pc: 85};
        tbl[2] = '{npairs: 0,  flush: 1'b1, exp_cycles: 0,  exp_words: 1, exp_last: 10, exp_busy: 0, exp_pc: 85};
        tbl[3] = '{npairs: 7,  flush: 1'b1, exp_cycles: 7,  exp_words: 1, exp_last: 7,  exp_busy: 0, exp_pc: 92};
        tbl[4] = '{npairs: 0,  flush: 1'b1, exp_cycles: 0,  exp_words: 0, exp_last: 0,  exp_busy: 0, exp_pc: 92};
        tbl[5] = '{npairs: 50, flush: 1'b0, exp_cycles: 51, exp_words: 2, exp_last: 25, exp_busy: 0, exp_pc: 142};

        bus.i_IDPair_Ready = 1'b0;
        bus.i_IDPair_Out   = '0;
        bus.i_Full         = 1'b0;
        bus.i_Flush        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        idle(1);

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            d0  = done_cnt;
            if (tbl[v].npairs > 0) begin
                send_pairs(tag, tbl[v].npairs, cyc);
                check({tag, "_cycles"}, cyc, tbl[v].exp_cycles);
            end
            if (tbl[v].flush) do_flush();
            idle(6);
            check_words(tag, tbl[v].exp_words, tbl[v].exp_last);
            check({tag, "_busy"}, int'(bus.o_Busy), tbl[v].exp_busy);
            check({tag, "_pc"}, int'(bus.o_PairCount), tbl[v].exp_pc);
            check({tag, "_flushdone"}, done_cnt - d0, int'(tbl[v].flush));
        end

        // Empty flush: done pulse two cycles after the request, no write.
        bus.i_Flush = 1'b1;
        @(negedge clk);
        check("eflush_t0", int'(bus.o_FlushDone), 0);
        @(posedge clk);
        #1;
        bus.i_Flush = 1'b0;
        @(negedge clk);
        check("eflush_t1", int'(bus.o_FlushDone), 0);
        @(negedge clk);
        check("eflush_t2", int'(bus.o_FlushDone), 1);
        @(negedge clk);
        check("eflush_t3", int'(bus.o_FlushDone), 0);
        idle(1);
        check("eflush_nwrite", got_q.size(), 0);

        // Flush coincident with a ready pair: pair must stay upstream.
        bus.i_IDPair_Ready = 1'b1;
        bus.i_IDPair_Out   = mk(seq);
        bus.i_Flush        = 1'b1;
        @(negedge clk);
        check("coflush_read", int'(bus.o_IDPair_Read), 0);
        @(posedge clk);
        #1;
        bus.i_Flush = 1'b0;
        @(negedge clk);
        check("coflush_move_read", int'(bus.o_IDPair_Read), 0);
        @(posedge clk);
        #1;
        bus.i_IDPair_Ready = 1'b0;
        idle(4);
        check("coflush_pc", int'(bus.o_PairCount), 142);
        check("coflush_nwrite", got_q.size(), 0);

        // Back-pressure: one word parked, a second fills the accumulator, then stall.
        bus.i_Full = 1'b1;
        send_pairs("stall", 25, cyc);
        check("stall_cycles", cyc, 25);
        pops = 0; writes = 0; stable_bad = 0; ref_word = '0;
        for (int i = 0; i < 30; i++) begin
            bus.i_IDPair_Ready = 1'b1;
            bus.i_IDPair_Out   = mk(seq);
            @(negedge clk);
            if (bus.o_IDPair_Read) begin
                model_pop();
                pops++;
            end
            if (bus.o_Write) writes++;
            if (i == 1) ref_word = bus.o_Word;
            if (i > 1 && bus.o_Word !== ref_word) stable_bad++;
            @(posedge clk);
            #1;
        end
        bus.i_IDPair_Ready = 1'b0;
        check("stall_pops", pops, 25);
        check("stall_writes", writes, 0);
        check("stall_word_unstable", stable_bad, 0);
        check_word("stall_parked", ref_word, exp_q[0]);
        check("stall_busy", int'(bus.o_Busy), 1);
        bus.i_Full = 1'b0;
        idle(6);
        check_words("stall", 2, 25);
        check("stall_pc", int'(bus.o_PairCount), 192);

        // Reset mid-word discards partial data.
        send_pairs("rst", 12, cyc);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        pend.delete();
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1);
        send_pairs("rst", 25, cyc);
        idle(4);
        check_words("rst", 1, 25);
        check("rst_pc", int'(bus.o_PairCount), 25);
        check("rst_busy", int'(bus.o_Busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
